segre_mem_responder: RTL
========================

# segre_mem_responder

Main-memory responder for the cache line request protocol driven by the instruction and data caches. It accepts one line read or line writeback at a time, holds it for a fixed, configurable latency, and then completes it with a one-cycle `mem_ready_o` pulse. On reads, the line is returned in the same cycle as the pulse. It sits between a cache's miss/writeback outputs and the backing store, and serves as both the simulation memory model and the synthesizable memory front end.

## Interface
- `ADDR_SIZE`, 32: request address width.
- `CACHE_LINE_SIZE_BYTES`, 16: line size in bytes; power of two.
- `MEM_DEPTH_LINES`, 1024: number of stored lines; power of two.
- `LATENCY`, 5: cycles from request acceptance to completion; must be ≥1.
- `clk_i`  in  1  clock; everything is on the rising edge.
- `rsn_i`  in  1  reset; one clock, asynchronous, active-low.
- `rd_i`  in  1  line read request; held by the requester until `mem_ready_o`.
- `wr_i`  in  1  line writeback request; held by the requester until `mem_ready_o`.
- `addr_i`  in  `ADDR_SIZE`  byte address of the request.
- `wr_line_i`  in  `CACHE_LINE_SIZE_BYTES`×8  line data to write, packed as `[bytes-1:0][7:0]`.
- `rd_line_o`  out  `CACHE_LINE_SIZE_BYTES`×8  registered read line.
- `mem_ready_o`  out  1  registered completion pulse; one cycle per transaction.
- `busy_o`  out  1  high while a transaction is outstanding (state ≠ IDLE).

## Operation
- **Line index:** `addr_i[log2(CACHE_LINE_SIZE_BYTES)+log2(MEM_DEPTH_LINES)-1 : log2(CACHE_LINE_SIZE_BYTES)]`.
  - Offset bits are ignored.
  - Upper bits are ignored, so addresses alias modulo `MEM_DEPTH_LINES`×`CACHE_LINE_SIZE_BYTES`.
- **Storage:** the array is not reset; contents are undefined until written.
- **FSM states:** IDLE, WAIT, DONE.
  - **IDLE:**
    - If `wr_i` is high, latch `wr_i`, the line index and `wr_line_i`; load the latency counter with `LATENCY-1`; go to WAIT.
    - Else if `rd_i` is high, latch the read and the index the same way; go to WAIT.
    - Otherwise stay in IDLE.
  - **WAIT:**
    - If counter == 0, perform the operation and go to DONE.
    - Otherwise decrement the counter.
    - `rd_i`, `wr_i`, `addr_i` and `wr_line_i` are ignored in this state; only latched values are used.
  - **DONE:** `mem_ready_o` = 1 for this cycle only; go to IDLE unconditionally.
- **Simultaneous `rd_i` and `wr_i` in IDLE:**
  - The write is served first; `rd_i` is not latched.
  - If the requester still holds `rd_i` when the FSM returns to IDLE, the read is served then. This is the writeback-then-refill order.
- **Performing the operation (edge leaving WAIT):**
  - Write: the array line is updated with the full latched line (no byte enables). `rd_line_o` is unchanged.
  - Read: `rd_line_o` is loaded with the array line.
  - Read-after-write to the same line returns the new data.
- **`rd_line_o` hold:** it holds its value until the next read completes. Requesters sample it only while `mem_ready_o` is high.
- **Held request after completion:** the requester must drop or change its request in the cycle after `mem_ready_o`. A request still high when the FSM re-enters IDLE is treated as a new transaction.
- **Reset (async assert):**
  - state = IDLE, counter = 0, `mem_ready_o` = 0, `busy_o` = 0, `rd_line_o` = 0.
  - Reset mid-transaction aborts it; an in-flight write is not committed.

## Timing
- **Latency:** request high in IDLE at edge k → WAIT from k.
  - The operation is committed at edge k+`LATENCY`.
  - `mem_ready_o` and the read data are valid in the cycle after edge k+`LATENCY`.
  - Back in IDLE after edge k+`LATENCY`+1.
- **`LATENCY`=1:** a single WAIT cycle; `mem_ready_o` is high in the cycle after edge k+1.
- **Throughput:** one transaction per `LATENCY`+2 cycles when requests are back-to-back.
- **`busy_o`:** rises in the cycle after edge k. It stays high through DONE and falls in the cycle after edge k+`LATENCY`+1.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Write then read:** write line 0x0000_0040 with pattern 0x0F..00, then read 0x0000_0048.
  - `rd_line_o` = 0x0F..00 during the read's `mem_ready_o`.
  - Exactly one ready pulse per transaction.
- **Latency count:** with `LATENCY`=5, `rd_i` is raised at edge 10 with a held request.
  - `mem_ready_o` is high only in the cycle after edge 15; `busy_o` is high for cycles 11–16.
- **Simultaneous requests:** `rd_i`=`wr_i`=1 to the same line with new data 0xAA…, both held.
  - Write completes first; the read completes `LATENCY`+2 cycles later, returning 0xAA….
- **Aliasing:** write to 0x0000_0010, read 0x0000_4010 with defaults (depth 1024 × 16 B = 0x4000 wrap).
  - The read returns the written line.
- **Reset mid-write:** assert `rsn_i` low for 1 cycle in WAIT of a write to line 3 (previously 0x11…).
  - All outputs drop to 0 immediately; no `mem_ready_o`.
  - A subsequent read of line 3 returns 0x11….
- **Request change during WAIT:** change `addr_i` and `wr_line_i` during WAIT.
  - The latched request is served; the changes have no effect.

Source files
------------

// File: rtl/segre_mem_responder.sv
// Line-granular main-memory responder for the cache request protocol.
// One read or writeback in flight, completed after a fixed latency.
module segre_mem_responder #(
    parameter int ADDR_SIZE             = 32,
    parameter int CACHE_LINE_SIZE_BYTES = 16,
    parameter int MEM_DEPTH_LINES       = 1024,
    parameter int LATENCY               = 5
) (
    input  logic                               clk_i,
    input  logic                               rsn_i,
    input  logic                               rd_i,
    input  logic                               wr_i,
    input  logic [ADDR_SIZE-1:0]               addr_i,
    input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] wr_line_i,
    output logic [CACHE_LINE_SIZE_BYTES*8-1:0] rd_line_o,
    output logic                               mem_ready_o,
    output logic                               busy_o
);

    localparam int LW    = CACHE_LINE_SIZE_BYTES * 8;
    localparam int OFF_W = $clog2(CACHE_LINE_SIZE_BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH_LINES);
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             wr_q;
    logic [IDX_W-1:0] idx_q;
    logic [LW-1:0]    line_q;
    logic [LW-1:0]    rd_line_q;
    logic             ready_q;
    logic             busy_q;

    logic [LW-1:0]    mem_q [MEM_DEPTH_LINES];

    logic [IDX_W-1:0] idx_in;
    logic             commit;
    logic             unused_addr;

    // Offset and upper address bits are dropped, so addresses alias.
    assign idx_in      = addr_i[OFF_W +: IDX_W];
    assign unused_addr = ^addr_i;
    assign commit      = (state_q == WAIT) && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            line_q    <= '0;
            rd_line_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wr_i || rd_i) begin
                        wr_q    <= wr_i;
                        idx_q   <= idx_in;
                        line_q  <= wr_line_i;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (!wr_q) begin
                            rd_line_q <= mem_q[idx_q];
                        end
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (commit && wr_q) begin
            mem_q[idx_q] <= line_q;
        end
    end

    assign rd_line_o   = rd_line_q;
    assign mem_ready_o = ready_q;
    assign busy_o      = busy_q;

endmodule
